shift_sequencer: RTL and testbench

- Command-driven controller for the 16-bit universal rotate register (4:1 mux plus D flip-flop per bit, no reset).
- Accepts load/rotate commands through a valid/ready interface and buffers them in a small FIFO.
- Drives the register's two mode-select lines and parallel-load word, holding each mode for exactly the commanded number of cycles.
- Sits beside the register in the parent; the register's q outputs are not read back.

---
 rtl/shift_sequencer.sv | 142 ++++++++++++++
 tb/tb_shift_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command FIFO plus FSM driving the mode lines of a 16-bit universal rotate register
// Every output is a register; the next-state logic also computes the next output values.
module shift_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             b0,
  output logic             b1,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [3:0]       amt;
    logic [WIDTH-1:0] data;
  } cmd_t;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             b0_nxt, b1_nxt, done_nxt, busy_nxt, ready_nxt;
  logic [WIDTH-1:0] d_nxt;

  assign push = cmd_valid && cmd_ready;
  assign head = mem[rd_ptr];

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_amt, cmd_data};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    b0_nxt    = 1'b1;
    b1_nxt    = 1'b1;
    d_nxt     = d_out;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          case (head.op)
            2'b00: begin
              state_nxt = LOAD;
              b0_nxt    = 1'b0;
              b1_nxt    = 1'b0;
              d_nxt     = head.data;
            end
            2'b01, 2'b10: begin
              if (head.amt != 4'd0) begin
                state_nxt = SHIFT;
                b0_nxt    = head.op[1];
                b1_nxt    = head.op[0];
                cnt_nxt   = head.amt - 4'd1;
              end else begin
                state_nxt = FINISH;
                done_nxt  = 1'b1;
              end
            end
            default: begin
              state_nxt = FINISH;
              done_nxt  = 1'b1;
            end
          endcase
        end
      end
      LOAD: begin
        state_nxt = FINISH;
        done_nxt  = 1'b1;
      end
      SHIFT: begin
        // The rotate code entered with amt-1 in cnt, so it stays up for amt cycles.
        if (cnt == 4'd0) begin
          state_nxt = FINISH;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
          b0_nxt  = b0;
          b1_nxt  = b1;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
    ready_nxt = (count_nxt != FULL);
    busy_nxt  = (count_nxt != '0) || (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      b0        <= 1'b1;
      b1        <= 1'b1;
      d_out     <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      count     <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      b0        <= b0_nxt;
      b1        <= b1_nxt;
      d_out     <= d_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      cmd_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - bench for shift_sequencer with a modelled rotate register and a command-level scoreboard
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b1;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_amt = 4'd0;
  logic [15:0] cmd_data = 16'hFFFF;
  logic        b0, b1;
  logic [15:0] d_out;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  shift_sequencer #(.FIFO_DEPTH(4), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .b0(b0), .b1(b1), .d_out(d_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // The external register this block drives; it has no reset.
  logic [15:0] q_reg = 16'h0000;
  always @(posedge clk) begin
    case ({b0, b1})
      2'b00: q_reg <= d_out;
      2'b01: q_reg <= {q_reg[14:0], q_reg[15]};
      2'b10: q_reg <= {q_reg[0], q_reg[15:1]};
      default: ;
    endcase
  end

  typedef struct {
    logic [1:0]  op;
    int          cyc;
    logic [15:0] q;
    logic [15:0] d;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] data;
    logic [15:0] exp_q;
    int          exp_cyc;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] model_q = 16'h0000;
  logic [15:0] model_d = 16'h0000;
  int          done_cnt = 0;
  int          run_cyc = 0;
  int          last_cyc = 0;
  logic [15:0] last_q = 16'h0000;
  logic        prev_rst = 1'b1;
  logic [1:0]  prev_mode = 2'b11;
  logic [1:0]  mon_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    logic [31:0] w;
    w = {v, v} << (n % 16);
    return w[31:16];
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] v, input int n);
    return rotl(v, 16 - (n % 16));
  endfunction

  // Scoreboard: every done pulse retires the oldest accepted command.
  always @(negedge clk) begin
    mon_mode = {b0, b1};
    if (rst || prev_rst) begin
      chk("done_near_reset", {31'd0, done}, 32'd0);
      run_cyc = 0;
    end else begin
      if (mon_mode != 2'b11) begin
        run_cyc++;
        if (exp_q.size() > 0) chk("mode_code", {30'd0, mon_mode}, {30'd0, exp_q[0].op});
        else chk("mode_without_cmd", {30'd0, mon_mode}, 32'd3);
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("done_without_cmd", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_q", {16'd0, q_reg}, {16'd0, mon_e.q});
          chk("sb_active_cycles", run_cyc, mon_e.cyc);
          chk("sb_d_out", {16'd0, d_out}, {16'd0, mon_e.d});
          if (mon_e.cyc > 0) chk("done_follows_active", {30'd0, prev_mode}, {30'd0, mon_e.op});
        end
        last_q   = q_reg;
        last_cyc = run_cyc;
        run_cyc  = 0;
      end
    end
    prev_rst  = rst;
    prev_mode = mon_mode;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic [1:0] op, input logic [3:0] amt, input logic [15:0] data,
                          output bit stalled);
    exp_t e;
    int k;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    cmd_valid = 1'b1;
    stalled   = 1'b0;
    k = 0;
    while (!cmd_ready && k < 200) begin
      stalled = 1'b1;
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      chk("push_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    case (op)
      2'b00: begin model_q = data; model_d = data; e.cyc = 1; end
      2'b01: begin model_q = rotl(model_q, int'(amt)); e.cyc = int'(amt); end
      2'b10: begin model_q = rotr(model_q, int'(amt)); e.cyc = int'(amt); end
      default: e.cyc = 0;
    endcase
    e.op = op;
    e.q  = model_q;
    e.d  = model_d;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_for(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("done_wait", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    bit st;
    int base, first_stall, act, k;

    vecs[0] = '{2'b00, 4'd0,  16'h8001, 16'h8001, 1};
    vecs[1] = '{2'b01, 4'd1,  16'h0000, 16'h0003, 1};
    vecs[2] = '{2'b00, 4'd0,  16'h00F0, 16'h00F0, 1};
    vecs[3] = '{2'b10, 4'd4,  16'hFFFF, 16'h000F, 4};
    vecs[4] = '{2'b00, 4'd9,  16'h1234, 16'h1234, 1};
    vecs[5] = '{2'b01, 4'd15, 16'h0000, 16'h091A, 15};
    vecs[6] = '{2'b01, 4'd1,  16'h0000, 16'h1234, 1};
    vecs[7] = '{2'b11, 4'd7,  16'hBEEF, 16'h1234, 0};
    vecs[8] = '{2'b01, 4'd0,  16'hBEEF, 16'h1234, 0};

    // Reset held two edges with a command offered
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_b0", {31'd0, b0}, 32'd1);
    chk("rst_b1", {31'd0, b1}, 32'd1);
    chk("rst_d_out", {16'd0, d_out}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    rst = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("nothing_pushed_busy", {31'd0, busy}, 32'd0);
    chk("nothing_pushed_done", done_cnt, 0);

    foreach (vecs[i]) begin
      base = done_cnt;
      push_cmd(vecs[i].op, vecs[i].amt, vecs[i].data, st);
      wait_for(base + 1);
      chk($sformatf("vec%0d_q", i), {16'd0, last_q}, {16'd0, vecs[i].exp_q});
      chk($sformatf("vec%0d_cycles", i), last_cyc, vecs[i].exp_cyc);
    end

    // Backpressure: long rotate executing, six commands offered back to back
    base = done_cnt;
    push_cmd(2'b01, 4'd15, 16'h0000, st);
    repeat (3) @(negedge clk);
    first_stall = -1;
    for (int i = 0; i < 6; i++) begin
      push_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom), st);
      if (st && first_stall < 0) first_stall = i;
    end
    chk("first_stall_index", first_stall, 4);
    wait_for(base + 7);
    chk("backpressure_done_count", done_cnt - base, 7);

    // Randomized commands with random gaps
    base = done_cnt;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom), st);
    end
    wait_for(base + 40);

    // Reset after the third active cycle of a 10-step rotate
    base = done_cnt;
    push_cmd(2'b00, 4'd0, 16'hA5C3, st);
    wait_for(base + 1);
    base = done_cnt;
    push_cmd(2'b01, 4'd10, 16'h0000, st);
    act = 0;
    k = 0;
    while (act < 3 && k < 50) begin
      @(negedge clk);
      k++;
      if ({b0, b1} == 2'b01) act++;
    end
    chk("saw_three_active", act, 3);
    rst = 1'b1;
    exp_q.delete();
    model_q = 16'h2E1D;
    model_d = 16'h0000;
    @(negedge clk);
    chk("busy_after_rst", {31'd0, busy}, 32'd0);
    chk("mode_after_rst", {30'd0, b0, b1}, 32'd3);
    chk("d_out_after_rst", {16'd0, d_out}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("partial_rotation_q", {16'd0, q_reg}, 32'h2E1D);
    chk("no_done_after_abort", done_cnt, base);
    chk("fifo_flushed_busy", {31'd0, busy}, 32'd0);

    // Still functional after the abort
    base = done_cnt;
    push_cmd(2'b10, 4'd3, 16'h0000, st);
    wait_for(base + 1);
    chk("post_reset_q", {16'd0, last_q}, 32'hA5C3);

    repeat (3) @(negedge clk);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_ready", {31'd0, cmd_ready}, 32'd1);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
